ras_ctrl: RTL and testbench
===========================

# ras_ctrl

Return-address-stack controller for the front-end predictor: accepts push (call) and pop (return) requests and returns predicted return addresses. Keeps the top entry in flops and spills the rest to a dual-port block RAM of DEPTH entries. The RAM is used as a circular buffer, so overflow silently discards the oldest entry. Absorbs the RAM's 1-cycle read latency with a one-cycle refill stall signalled through `ready_o`.

## Interface
- `DEPTH`, 32: RAM entries (power of two, ≥2); total capacity DEPTH+1.
- `WIDTH`, 32: return-address width.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `push_i` in 1: push request; taken only when `ready_o`=1.
- `push_addr_i` in WIDTH: address to push.
- `pop_i` in 1: pop request; taken only when `ready_o`=1.
- `ready_o` out 1: push/pop accepted this cycle.
- `pop_valid_o` out 1: registered; pop result valid this cycle.
- `pop_addr_o` out WIDTH: registered popped address; 0 on underflow.
- `underflow_o` out 1: registered pulse with `pop_valid_o` when the stack was empty.
- `overflow_o` out 1: registered pulse after a push that discarded the oldest entry.
- `count_o` out $clog2(DEPTH+2): occupancy 0..DEPTH+1.

## Operation
- State: `top_q`, `top_v`, RAM write pointer `ptr` (mod DEPTH), RAM occupancy `bcnt` (0..DEPTH), FSM {IDLE, REFILL}.
- RAM ports: A read-only (`rea`, `raddra`=ptr-1 mod DEPTH, `wea`=0); B write-only (`web`, `waddrb`=ptr, `wib`=top_q, `reb`=0).
- `ready_o` = (state==IDLE) && !rst.
- IDLE, push only: if `top_v`, write top_q to RAM[ptr], ptr++, bcnt = min(bcnt+1, DEPTH); `overflow_o` next cycle if bcnt was DEPTH. top_q←push_addr_i, top_v←1.
- IDLE, pop only, `top_v`=1: next cycle `pop_valid_o`=1, `pop_addr_o`=top_q. If bcnt>0: assert `rea` this cycle, ptr--, bcnt--, go REFILL. Else top_v←0, stay IDLE.
- IDLE, pop with `top_v`=0: `pop_valid_o`=1, `pop_addr_o`=0, `underflow_o`=1 next cycle; no state change.
- IDLE, push+pop same cycle: pop returns old top_q (0 + underflow if `top_v`=0); top_q←push_addr_i, top_v←1; no RAM access, ptr/bcnt unchanged.
- REFILL (one cycle): top_q←`doa`, top_v stays 1, return IDLE. Requests are ignored (ready low).
- `count_o` = bcnt + top_v.
- No port-A/port-B address collision occurs by construction (push-only never reads; pop-only never writes).
- Reset: ptr=0, bcnt=0, top_v=0, top_q=0, state IDLE. All outputs 0 except `ready_o`, which goes to 1 in the first cycle after reset deasserts. RAM contents are not cleared. Reset during REFILL discards `doa`.

## Timing
- Push accepted at edge t → `count_o` updated after t, RAM written at t.
- Pop accepted at edge t → `pop_valid_o`/`pop_addr_o` in cycle t+1 (1-cycle latency).
- With refill: `ready_o`=0 in cycle t+1, 1 again in t+2. Max pop throughput is 1 per 2 cycles while RAM nonempty; push and push+pop sustain 1 per cycle.
- `overflow_o`/`underflow_o` are single-cycle pulses aligned with the cycle after acceptance.

## Structure
- Package `ras_pkg`: FSM state enum (`RAS_IDLE`, `RAS_REFILL`).
- Single sub-module: `ras_bram` instance (DEPTH, WIDTH) with ports split as above. All other logic lives in `ras_ctrl`.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles, then three pops honouring `ready_o` → pop_addr_o 0x300, 0x200, 0x100. `ready_o` low one cycle after each of the first two pops; count 3→0.
- Pop on an empty stack → `pop_valid_o`=1, `pop_addr_o`=0, `underflow_o`=1; count stays 0.
- With DEPTH=4, push 6 values 1..6 → `overflow_o` on the 6th push only, count=5. Five pops return 6,5,4,3,2; sixth pop underflows.
- Push 0xA, then push+pop with 0xB → pop returns 0xA, count stays 1; next pop returns 0xB.
- Push 0xA, 0xB, pop, then assert push/pop during the REFILL cycle → both ignored. Next pop returns 0xA.
- Assert `rst` in the REFILL cycle → count 0, `ready_o`=1 after release, next pop underflows.

Source files
------------

// File: rtl/ras_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ras_pkg
// Description : Shared types for the return-address-stack controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ras_pkg;

    typedef enum logic [0:0] {
        RAS_IDLE   = 1'b0,
        RAS_REFILL = 1'b1
    } ras_state_t;

endpackage
`default_nettype wire

// File: rtl/ras_bram.sv
`default_nettype none
// ============================================================================
// Module      : ras_bram
// Description : Dual-port block RAM, port A read-only, port B write-only,
//               1-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_bram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rea,
    input  logic [$clog2(DEPTH)-1:0] raddra,
    output logic [WIDTH-1:0]         doa,
    input  logic                     web,
    input  logic [$clog2(DEPTH)-1:0] waddrb,
    input  logic [WIDTH-1:0]         wib
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (web) begin
            r_mem[waddrb] <= wib;
        end
    end

    always_ff @(posedge clk) begin
        if (rea) begin
            doa <= r_mem[raddra];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ras_ctrl
// Description : Return-address stack: top entry in flops, remainder spilled
//               to a circular block RAM; one-cycle refill stall after pops.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_addr_i,
    input  logic                       pop_i,
    output logic                       ready_o,
    output logic                       pop_valid_o,
    output logic [WIDTH-1:0]           pop_addr_o,
    output logic                       underflow_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH+2)-1:0] count_o
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH+2);
    localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_BCNT_MAX = c_CW'(DEPTH);

    ras_state_t       r_state;
    ras_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_top_q;
    logic             r_top_v;
    logic [c_PW-1:0]  r_ptr;
    logic [c_CW-1:0]  r_bcnt;
    logic             r_pop_valid;
    logic [WIDTH-1:0] r_pop_addr;
    logic             r_underflow;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic             w_push_only;
    logic             w_pop_only;
    logic             w_both;
    logic             w_bram_nonempty;
    logic             w_rea;
    logic             w_web;
    logic [c_PW-1:0]  w_raddra;
    logic [WIDTH-1:0] w_doa;

    // Acceptance is gated by rst so the RAM is never touched during reset.
    assign ready_o         = (r_state == RAS_IDLE) && !rst;
    assign w_push          = ready_o && push_i;
    assign w_pop           = ready_o && pop_i;
    assign w_both          = w_push && w_pop;
    assign w_push_only     = w_push && !w_pop;
    assign w_pop_only      = w_pop && !w_push;
    assign w_bram_nonempty = (r_bcnt != '0);
    assign w_rea           = w_pop_only && r_top_v && w_bram_nonempty;
    assign w_web           = w_push_only && r_top_v;
    assign w_raddra        = r_ptr - c_PTR_ONE;

    assign pop_valid_o = r_pop_valid;
    assign pop_addr_o  = r_pop_addr;
    assign underflow_o = r_underflow;
    assign overflow_o  = r_overflow;
    assign count_o     = r_bcnt + c_CW'(r_top_v);

    ras_bram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_bram (
        .clk    (clk),
        .rea    (w_rea),
        .raddra (w_raddra),
        .doa    (w_doa),
        .web    (w_web),
        .waddrb (r_ptr),
        .wib    (r_top_q)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RAS_IDLE:   if (w_rea) w_state_nxt = RAS_REFILL;
            RAS_REFILL: w_state_nxt = RAS_IDLE;
            default:    w_state_nxt = RAS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RAS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_top_q     <= '0;
            r_top_v     <= 1'b0;
            r_ptr       <= '0;
            r_bcnt      <= '0;
            r_pop_valid <= 1'b0;
            r_pop_addr  <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_pop_valid <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;

            if (r_state == RAS_REFILL) begin
                r_top_q <= w_doa;
            end

            if (w_pop) begin
                r_pop_valid <= 1'b1;
                r_pop_addr  <= r_top_v ? r_top_q : '0;
                r_underflow <= !r_top_v;
            end

            if (w_push) begin
                r_top_q <= push_addr_i;
                r_top_v <= 1'b1;
            end

            // Circular spill: at full occupancy the write overwrites the oldest entry.
            if (w_web) begin
                r_ptr <= r_ptr + c_PTR_ONE;
                if (r_bcnt == c_BCNT_MAX) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_bcnt <= r_bcnt + c_CNT_ONE;
                end
            end

            if (w_pop_only && r_top_v) begin
                if (w_bram_nonempty) begin
                    r_ptr  <= r_ptr - c_PTR_ONE;
                    r_bcnt <= r_bcnt - c_CNT_ONE;
                end else begin
                    r_top_v <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ras_ctrl
// Description : Directed self-checking bench for ras_ctrl (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ras_ctrl;

    localparam int c_DEPTH = 4;
    localparam int c_WIDTH = 32;
    localparam int c_CW    = $clog2(c_DEPTH+2);

    logic               clk;
    logic               rst;
    logic               push_i;
    logic [c_WIDTH-1:0] push_addr_i;
    logic               pop_i;
    logic               ready_o;
    logic               pop_valid_o;
    logic [c_WIDTH-1:0] pop_addr_o;
    logic               underflow_o;
    logic               overflow_o;
    logic [c_CW-1:0]    count_o;

    int n_checks = 0;
    int n_fails  = 0;

    ras_ctrl #(
        .DEPTH (c_DEPTH),
        .WIDTH (c_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_i),
        .push_addr_i (push_addr_i),
        .pop_i       (pop_i),
        .ready_o     (ready_o),
        .pop_valid_o (pop_valid_o),
        .pop_addr_o  (pop_addr_o),
        .underflow_o (underflow_o),
        .overflow_o  (overflow_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 8) begin
            step();
            n++;
        end
        if (!ready_o) check_eq("ready_timeout", 64'(ready_o), 64'd1);
    endtask

    task automatic do_push(input logic [c_WIDTH-1:0] a, input logic exp_ovf);
        wait_ready();
        push_i      = 1'b1;
        push_addr_i = a;
        step();
        push_i      = 1'b0;
        check_eq("push_ovf", 64'(overflow_o), 64'(exp_ovf));
    endtask

    task automatic do_pop(input string tag, input logic [c_WIDTH-1:0] exp_addr,
                          input logic exp_uf, input logic exp_rdy);
        wait_ready();
        pop_i = 1'b1;
        step();
        pop_i = 1'b0;
        check_eq({tag, "_valid"}, 64'(pop_valid_o), 64'd1);
        check_eq({tag, "_addr"},  64'(pop_addr_o),  64'(exp_addr));
        check_eq({tag, "_uf"},    64'(underflow_o), 64'(exp_uf));
        check_eq({tag, "_rdy"},   64'(ready_o),     64'(exp_rdy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0;
        step();
        step();
        check_eq("rst_ready", 64'(ready_o), 64'd0);
        check_eq("rst_count", 64'(count_o), 64'd0);
        check_eq("rst_valid", 64'(pop_valid_o), 64'd0);
        check_eq("rst_ovf",   64'(overflow_o), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 64'(ready_o), 64'd1);

        // Basic LIFO with refill stalls
        do_push(32'h100, 1'b0);
        do_push(32'h200, 1'b0);
        do_push(32'h300, 1'b0);
        check_eq("t1_count3", 64'(count_o), 64'd3);
        do_pop("t1_p0", 32'h300, 1'b0, 1'b0);
        check_eq("t1_count2", 64'(count_o), 64'd2);
        step();
        check_eq("t1_rdy_back", 64'(ready_o), 64'd1);
        do_pop("t1_p1", 32'h200, 1'b0, 1'b0);
        do_pop("t1_p2", 32'h100, 1'b0, 1'b1);
        check_eq("t1_count0", 64'(count_o), 64'd0);
        step();
        check_eq("t1_valid_clr", 64'(pop_valid_o), 64'd0);

        // Underflow
        do_pop("t2_uf", 32'h0, 1'b1, 1'b1);
        check_eq("t2_count", 64'(count_o), 64'd0);

        // Overflow with DEPTH=4
        for (int i = 1; i <= 6; i++) begin
            do_push(32'(i), (i == 6) ? 1'b1 : 1'b0);
        end
        check_eq("t3_count5", 64'(count_o), 64'd5);
        step();
        check_eq("t3_ovf_pulse", 64'(overflow_o), 64'd0);
        for (int i = 6; i >= 2; i--) begin
            do_pop("t3_p", 32'(i), 1'b0, (i == 2) ? 1'b1 : 1'b0);
        end
        do_pop("t3_uf", 32'h0, 1'b1, 1'b1);
        check_eq("t3_count0", 64'(count_o), 64'd0);

        // Simultaneous push+pop
        do_push(32'hA, 1'b0);
        wait_ready();
        push_i = 1'b1; pop_i = 1'b1; push_addr_i = 32'hB;
        step();
        push_i = 1'b0; pop_i = 1'b0;
        check_eq("t4_valid", 64'(pop_valid_o), 64'd1);
        check_eq("t4_addr",  64'(pop_addr_o),  64'hA);
        check_eq("t4_uf",    64'(underflow_o), 64'd0);
        check_eq("t4_count", 64'(count_o),     64'd1);
        check_eq("t4_rdy",   64'(ready_o),     64'd1);
        do_pop("t4_p", 32'hB, 1'b0, 1'b1);

        // Requests during REFILL are ignored
        do_push(32'hA, 1'b0);
        do_push(32'hB, 1'b0);
        do_pop("t5_p0", 32'hB, 1'b0, 1'b0);
        push_i = 1'b1; pop_i = 1'b1; push_addr_i = 32'hC;
        step();
        push_i = 1'b0; pop_i = 1'b0;
        check_eq("t5_ign_valid", 64'(pop_valid_o), 64'd0);
        check_eq("t5_ign_count", 64'(count_o),     64'd1);
        do_pop("t5_p1", 32'hA, 1'b0, 1'b1);
        check_eq("t5_count0", 64'(count_o), 64'd0);

        // Reset in the REFILL cycle
        do_push(32'hD, 1'b0);
        do_push(32'hE, 1'b0);
        do_pop("t6_p0", 32'hE, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("t6_count", 64'(count_o), 64'd0);
        check_eq("t6_ready", 64'(ready_o), 64'd1);
        check_eq("t6_valid", 64'(pop_valid_o), 64'd0);
        do_pop("t6_uf", 32'h0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
